// File: rtl/pwm_duty_ctrl.sv
// Push-button adjustable PWM generator: synchronised up/down buttons with optional
// hold-to-repeat, clamped duty request, and a duty shadow register loaded at period wrap.
module pwm_duty_ctrl #(
  parameter int WIDTH      = 5,
  parameter int PERIOD     = 20,
  parameter int DUTY_INIT  = 10,
  parameter int DUTY_MIN   = 1,
  parameter int DUTY_MAX   = 19,
  parameter int STEP       = 1,
  parameter int REPEAT_CYC = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pshbtn_p,
  input  logic             pshbtn_m,
  output logic [WIDTH-1:0] t_high,
  output logic [WIDTH-1:0] t_low,
  output logic             pwm_out,
  output logic             period_start
);

  localparam int RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam bit RPT_EN = (REPEAT_CYC > 0);
  localparam logic [RW-1:0]    RPT_LAST = RW'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH-1:0] PER_W    = WIDTH'(PERIOD);
  localparam logic [WIDTH-1:0] INIT_W   = WIDTH'(DUTY_INIT);
  localparam logic [WIDTH:0]   DMAX_X   = (WIDTH+1)'(DUTY_MAX);
  localparam logic [WIDTH:0]   DMIN_X   = (WIDTH+1)'(DUTY_MIN);
  localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);

  // One extra bit keeps the sum from wrapping before the clamp compare.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sum;
    sum = {1'b0, d} + STEP_X;
    return (sum > DMAX_X) ? DMAX_X[WIDTH-1:0] : sum[WIDTH-1:0];
  endfunction

  // Compare before subtracting so the result never underflows.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] dif;
    if ({1'b0, d} < DMIN_X + STEP_X) return DMIN_X[WIDTH-1:0];
    dif = {1'b0, d} - STEP_X;
    return dif[WIDTH-1:0];
  endfunction

  logic s1_p, s2_p, s3_p;
  logic s1_m, s2_m, s3_m;
  logic rise_p, rise_m, one_held, rpt_hit, rpt_p, rpt_m, inc_ev, dec_ev, wrap;
  logic [RW-1:0]    rcnt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_req;
  logic [WIDTH-1:0] duty_act;

  // Stage: button synchronisers and edge-detect delay flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {s1_p, s2_p, s3_p} <= '0;
      {s1_m, s2_m, s3_m} <= '0;
    end else begin
      {s1_p, s2_p, s3_p} <= {pshbtn_p, s1_p, s2_p};
      {s1_m, s2_m, s3_m} <= {pshbtn_m, s1_m, s2_m};
    end
  end

  assign rise_p   = s2_p & ~s3_p;
  assign rise_m   = s2_m & ~s3_m;
  assign one_held = s2_p ^ s2_m;
  assign rpt_hit  = RPT_EN && one_held && (rcnt == RPT_LAST);
  assign rpt_p    = rpt_hit & s2_p;
  assign rpt_m    = rpt_hit & s2_m;
  assign inc_ev   = (rise_p | rpt_p) & ~s2_m;
  assign dec_ev   = (rise_m | rpt_m) & ~s2_p;
  assign wrap     = (cnt == CNT_LAST);

  // Stage: hold-to-repeat interval counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
    end else if (!RPT_EN || rise_p || rise_m || !one_held || rpt_hit) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // Stage: duty request, period counter and shadow duty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_req <= INIT_W;
      duty_act <= INIT_W;
      cnt      <= '0;
    end else begin
      if (inc_ev && !dec_ev) begin
        duty_req <= sat_inc(duty_req);
      end else if (dec_ev && !inc_ev) begin
        duty_req <= sat_dec(duty_req);
      end
      if (wrap) begin
        cnt      <= '0;
        duty_act <= duty_req;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign t_high       = duty_req;
  assign t_low        = PER_W - duty_req;
  assign pwm_out      = (cnt < duty_act);
  assign period_start = (cnt == '0);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Scoreboard bench for pwm_duty_ctrl: a behavioural model queues the expected outputs
// each edge, a negedge monitor pops and compares, plus directed checks from the test plan.
module tb_pwm_duty_ctrl;
  localparam int W    = 5;
  localparam int PER  = 20;
  localparam int INIT = 10;
  localparam int DMIN = 1;
  localparam int DMAX = 19;
  localparam int STP  = 1;
  localparam int RPT  = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pshbtn_p = 1'b0;
  logic pshbtn_m = 1'b0;
  logic [W-1:0] t_high, t_low;
  logic pwm_out, period_start;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_duty_ctrl #(
    .WIDTH(W), .PERIOD(PER), .DUTY_INIT(INIT), .DUTY_MIN(DMIN),
    .DUTY_MAX(DMAX), .STEP(STP), .REPEAT_CYC(RPT)
  ) dut (
    .clk(clk), .reset(reset), .pshbtn_p(pshbtn_p), .pshbtn_m(pshbtn_m),
    .t_high(t_high), .t_low(t_low), .pwm_out(pwm_out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] th;
    logic [W-1:0] tl;
    logic         pw;
    logic         ps;
  } exp_t;
  exp_t q[$];

  // Behavioural model state
  int m_req, m_act, m_cnt, m_rc, nreq;
  bit hp1, hp2, hp3, hm1, hm2, hm3;
  bit rp, rm, one, hit, ip, dm;

  function automatic exp_t model_out();
    exp_t e;
    e.th = W'(m_req);
    e.tl = W'(PER - m_req);
    e.pw = (m_cnt < m_act);
    e.ps = (m_cnt == 0);
    return e;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_req = INIT; m_act = INIT; m_cnt = 0; m_rc = 0;
      {hp1, hp2, hp3, hm1, hm2, hm3} = '0;
      q.delete();
    end else begin
      rp  = hp2 && !hp3;
      rm  = hm2 && !hm3;
      one = (hp2 != hm2);
      hit = one && (m_rc == RPT - 1);
      ip  = (rp || (hit && hp2)) && !hm2;
      dm  = (rm || (hit && hm2)) && !hp2;
      nreq = m_req;
      if (ip && !dm)      nreq = (m_req + STP > DMAX) ? DMAX : m_req + STP;
      else if (dm && !ip) nreq = (m_req - STP < DMIN) ? DMIN : m_req - STP;
      if (m_cnt == PER - 1) m_act = m_req;
      m_cnt = (m_cnt + 1) % PER;
      m_rc  = (rp || rm || !one || hit) ? 0 : m_rc + 1;
      m_req = nreq;
      hp3 = hp2; hp2 = hp1; hp1 = pshbtn_p;
      hm3 = hm2; hm2 = hm1; hm1 = pshbtn_m;
    end
    q.push_back(model_out());
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_t_high", t_high, e.th);
      chk("sb_t_low", t_low, e.tl);
      chk("sb_pwm_out", pwm_out, e.pw);
      chk("sb_period_start", period_start, e.ps);
    end
  end

  task automatic press(input bit up, input int hold, input int gap);
    @(posedge clk); #1;
    if (up) pshbtn_p = 1'b1; else pshbtn_m = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    if (up) pshbtn_p = 1'b0; else pshbtn_m = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cnt;
    bit seen7;
    // Reset state
    reset = 1'b1;
    #2;
    chk("rst_t_high", t_high, 10);
    chk("rst_t_low", t_low, 10);
    chk("rst_period_start", period_start, 1);
    chk("rst_pwm_out", pwm_out, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle periods: count high cycles over one full period
    repeat (20) @(posedge clk);
    hi_cnt = 0;
    repeat (PER) begin
      @(negedge clk);
      if (pwm_out === 1'b1) hi_cnt++;
    end
    chk("idle_high_cycles", hi_cnt, 10);
    repeat (5) @(posedge clk);

    // Single press: update on the third sampling edge
    @(posedge clk); #1 pshbtn_p = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("press_before", t_high, 10);
    @(posedge clk);
    @(negedge clk);
    chk("press_after", t_high, 11);
    chk("press_t_low", t_low, 9);
    @(posedge clk); #1 pshbtn_p = 1'b0;
    repeat (45) @(posedge clk);

    // Saturation at the top, then step down and saturate at the bottom
    for (int i = 0; i < 15; i++) press(1'b1, 3, 3);
    @(negedge clk);
    chk("sat_hi_t_high", t_high, 19);
    chk("sat_hi_t_low", t_low, 1);
    press(1'b0, 3, 3);
    @(negedge clk);
    chk("dec_from_max", t_high, 18);
    for (int i = 0; i < 25; i++) press(1'b0, 3, 3);
    @(negedge clk);
    chk("sat_lo_t_high", t_high, 1);
    chk("sat_lo_t_low", t_low, 19);
    press(1'b1, 3, 3);
    @(negedge clk);
    chk("inc_from_min", t_high, 2);

    // Both buttons together: no change
    @(posedge clk); #1;
    pshbtn_p = 1'b1; pshbtn_m = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    pshbtn_p = 1'b0; pshbtn_m = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("both_held", t_high, 2);

    // Hold to repeat: five steps in 40 held cycles
    press(1'b1, 40, 5);
    @(negedge clk);
    chk("repeat_hold", t_high, 7);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("repeat_release", t_high, 7);

    // Raise duty to 14, then async reset at cnt 7 with the button held through it
    for (int i = 0; i < 7; i++) press(1'b1, 3, 3);
    @(negedge clk);
    chk("pre_reset_duty", t_high, 14);
    seen7 = 1'b0;
    for (int i = 0; i < 60 && !seen7; i++) begin
      @(posedge clk); #1;
      if (m_cnt == 7) seen7 = 1'b1;
    end
    chk("reach_cnt7", seen7, 1);
    pshbtn_p = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_t_high", t_high, 10);
    chk("async_t_low", t_low, 10);
    chk("async_period_start", period_start, 1);
    @(posedge clk); #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("held_thru_reset", t_high, 11);
    chk("restart_cnt", period_start, 0);
    @(posedge clk); #1 pshbtn_p = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
